// File: rtl/div_unit_seq.sv
// Multicycle signed integer divider: restoring shift-subtract, one quotient
// bit per clock. The FSM walks IDLE -> RUN (WIDTH iterations) -> FIX (sign
// correction) -> DONE (one-cycle completion pulse). A zero divisor skips RUN
// and FIX and goes straight to DONE with the exception flag set.
module div_unit_seq #(
    parameter  int WIDTH = 32,
    localparam int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             ctrl_div,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    output logic [WIDTH-1:0] data_result,
    output logic [WIDTH-1:0] data_remainder,
    output logic             data_exception,
    output logic             data_resultRDY,
    output logic             busy
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX, S_DONE} state_t;

    state_t state, state_nxt;

    logic signed [WIDTH-1:0] op_a_s;
    logic signed [WIDTH-1:0] op_b_s;

    logic [CNT_W-1:0] cnt_r;
    logic [WIDTH-1:0] rem_r;     // partial remainder, always < |B|
    logic [WIDTH-1:0] quo_r;     // dividend bits shift out, quotient bits shift in
    logic [WIDTH-1:0] mag_b_r;
    logic             sign_a_r;
    logic             sign_b_r;

    logic              accept;
    logic              b_zero;
    logic              cnt_last;
    logic [WIDTH:0]    rem_sh;
    logic signed [WIDTH:0] trial;
    logic              trial_neg;

    // Magnitude of a two's complement value; the most negative value maps to
    // 2^(WIDTH-1), which still fits when held unsigned.
    function automatic logic [WIDTH-1:0] magnitude(input logic signed [WIDTH-1:0] v);
        logic [WIDTH-1:0] m;
        m = v[WIDTH-1] ? -v : v;
        return m;
    endfunction

    // Conditional two's complement negation used for the final sign fix.
    function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v, input logic neg);
        return neg ? -v : v;
    endfunction

    assign op_a_s   = data_operandA;
    assign op_b_s   = data_operandB;
    assign accept   = ctrl_div && ((state == S_IDLE) || (state == S_DONE));
    assign b_zero   = (data_operandB == '0);
    assign cnt_last = (cnt_r == CNT_W'(WIDTH - 1));

    // Trial subtraction of one restoring step; a negative result means restore.
    always_comb begin
        rem_sh    = {rem_r, quo_r[WIDTH-1]};
        trial     = $signed(rem_sh) - $signed({1'b0, mag_b_r});
        trial_neg = trial[WIDTH];
    end

    // Next-state logic and state-decoded handshake outputs.
    always_comb begin
        state_nxt      = state;
        data_resultRDY = 1'b0;
        busy           = 1'b0;
        case (state)
            S_IDLE, S_DONE: begin
                data_resultRDY = (state == S_DONE);
                if (accept) begin
                    state_nxt = b_zero ? S_DONE : S_RUN;
                end else begin
                    state_nxt = S_IDLE;
                end
            end
            S_RUN: begin
                busy = 1'b1;
                if (cnt_last) begin
                    state_nxt = S_FIX;
                end
            end
            S_FIX: begin
                busy      = 1'b1;
                state_nxt = S_DONE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Operand capture and one shift-subtract iteration per RUN cycle.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt_r    <= '0;
            rem_r    <= '0;
            quo_r    <= '0;
            mag_b_r  <= '0;
            sign_a_r <= 1'b0;
            sign_b_r <= 1'b0;
        end else if (accept && !b_zero) begin
            cnt_r    <= '0;
            rem_r    <= '0;
            quo_r    <= magnitude(op_a_s);
            mag_b_r  <= magnitude(op_b_s);
            sign_a_r <= op_a_s[WIDTH-1];
            sign_b_r <= op_b_s[WIDTH-1];
        end else if (state == S_RUN) begin
            rem_r <= trial_neg ? rem_sh[WIDTH-1:0] : trial[WIDTH-1:0];
            quo_r <= {quo_r[WIDTH-2:0], ~trial_neg};
            cnt_r <= cnt_r + CNT_W'(1);
        end
    end

    // Result registers: written only on a FIX edge or a divide-by-zero accept.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            data_result    <= '0;
            data_remainder <= '0;
            data_exception <= 1'b0;
        end else if (accept && b_zero) begin
            data_result    <= '0;
            data_remainder <= '0;
            data_exception <= 1'b1;
        end else if (state == S_FIX) begin
            data_result    <= cond_neg(quo_r, sign_a_r ^ sign_b_r);
            data_remainder <= cond_neg(rem_r, sign_a_r);
            data_exception <= 1'b0;
        end
    end

endmodule

// File: tb/tb_div_unit_seq.sv
// Self-checking bench for div_unit_seq (WIDTH = 32). Expected results are
// pushed to a scoreboard queue when an operation is issued and popped when
// data_resultRDY is seen.
module tb_div_unit_seq;

    localparam int W = 32;

    logic         clock = 1'b0;
    logic         reset_n = 1'b1;
    logic         ctrl_div = 1'b0;
    logic [W-1:0] op_a = '0;
    logic [W-1:0] op_b = '0;
    logic [W-1:0] data_result;
    logic [W-1:0] data_remainder;
    logic         data_exception;
    logic         data_resultRDY;
    logic         busy;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [W-1:0] res;
        logic [W-1:0] rem;
        logic         exc;
    } exp_t;

    exp_t sb[$];

    div_unit_seq #(.WIDTH(W)) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .ctrl_div       (ctrl_div),
        .data_operandA  (op_a),
        .data_operandB  (op_b),
        .data_result    (data_result),
        .data_remainder (data_remainder),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY),
        .busy           (busy)
    );

    always #5 clock = ~clock;

    // Advance one clock and sample 1 ns after the rising edge.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Issue one operation (accepted on the next edge) and record its expectation.
    task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic [W-1:0] res, input logic [W-1:0] rem,
                            input logic exc);
        exp_t e;
        e.res = res;
        e.rem = rem;
        e.exc = exc;
        sb.push_back(e);
        ctrl_div = 1'b1;
        op_a = a;
        op_b = b;
        step();
        ctrl_div = 1'b0;
        op_a = $urandom;
        op_b = $urandom;
    endtask

    // Wait for data_resultRDY, then pop the scoreboard and compare.
    // elapsed = edges already seen since the accepting edge.
    task automatic collect(input string name, input int exp_edges, input int elapsed,
                           output int busy_cnt);
        int   n;
        bit   got;
        exp_t e;
        n = elapsed;
        got = 1'b0;
        busy_cnt = 0;
        while (1) begin
            if (data_resultRDY) begin
                got = 1'b1;
                break;
            end
            if (n >= exp_edges + 20) break;
            if (busy) busy_cnt++;
            step();
            n++;
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL %s timeout: no data_resultRDY after %0d edges, required at %0d", name, n, exp_edges);
            if (sb.size() > 0) void'(sb.pop_front());
            return;
        end
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL %s unexpected_rdy: scoreboard empty at completion", name);
            return;
        end
        e = sb.pop_front();
        checks++;
        if (n !== exp_edges) begin
            errors++;
            $display("FAIL %s latency: got %0d edges, required %0d", name, n, exp_edges);
        end
        checks++;
        if (data_result !== e.res) begin
            errors++;
            $display("FAIL %s result: got %h, required %h", name, data_result, e.res);
        end
        checks++;
        if (data_remainder !== e.rem) begin
            errors++;
            $display("FAIL %s remainder: got %h, required %h", name, data_remainder, e.rem);
        end
        checks++;
        if (data_exception !== e.exc) begin
            errors++;
            $display("FAIL %s exception: got %b, required %b", name, data_exception, e.exc);
        end
    endtask

    task automatic test_reset();
        #1 reset_n = 1'b0;
        #1;
        step();
        step();
        checks++;
        if ({data_result, data_remainder, data_exception, data_resultRDY, busy} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got res=%h rem=%h exc=%b rdy=%b busy=%b, required all 0",
                     data_result, data_remainder, data_exception, data_resultRDY, busy);
        end
        @(negedge clock);
        reset_n = 1'b1;
        step();
        checks++;
        if (data_resultRDY !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: got rdy=%b busy=%b, required 0 0", data_resultRDY, busy);
        end
    endtask

    task automatic test_basic();
        int bc;
        start_op(32'd100, 32'd7, 32'd14, 32'd2, 1'b0);
        collect("basic_100_7", 33, 0, bc);
        checks++;
        if (bc !== 33) begin
            errors++;
            $display("FAIL basic_busy_cycles: got %0d, required 33", bc);
        end
        step();
        checks++;
        if (data_resultRDY !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL basic_rdy_pulse: got rdy=%b busy=%b one cycle after DONE, required 0 0",
                     data_resultRDY, busy);
        end
        checks++;
        if (data_result !== 32'd14 || data_remainder !== 32'd2) begin
            errors++;
            $display("FAIL basic_hold_idle: got %h/%h, required 0000000e/00000002",
                     data_result, data_remainder);
        end
    endtask

    task automatic test_signed();
        int bc;
        start_op(32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b0);
        collect("signed_m100_7", 33, 0, bc);
        step();
        start_op(32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF2, 32'd2, 1'b0);
        collect("signed_100_m7", 33, 0, bc);
        step();
        start_op(32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'd14, 32'hFFFF_FFFE, 1'b0);
        collect("signed_m100_m7", 33, 0, bc);
        step();
    endtask

    task automatic test_div_zero();
        int bc;
        start_op(32'd5, 32'd0, 32'd0, 32'd0, 1'b1);
        collect("div_zero", 0, 0, bc);
        step();
        checks++;
        if (data_resultRDY !== 1'b0 || data_exception !== 1'b1) begin
            errors++;
            $display("FAIL div_zero_after: got rdy=%b exc=%b, required 0 1", data_resultRDY, data_exception);
        end
        start_op(32'd9, 32'd3, 32'd3, 32'd0, 1'b0);
        collect("div_zero_clear", 33, 0, bc);
        step();
    endtask

    task automatic test_overflow();
        int bc;
        start_op(32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b0);
        collect("ovf_min_m1", 33, 0, bc);
        step();
        start_op(32'h8000_0000, 32'd1, 32'h8000_0000, 32'd0, 1'b0);
        collect("ovf_min_1", 33, 0, bc);
        step();
        start_op(32'd7, 32'h8000_0000, 32'd0, 32'd7, 1'b0);
        collect("div_by_min", 33, 0, bc);
        step();
        start_op(32'h8000_0000, 32'h8000_0000, 32'd1, 32'd0, 1'b0);
        collect("min_by_min", 33, 0, bc);
        step();
    endtask

    task automatic test_ignore_restart();
        int bc;
        start_op(32'd100, 32'd7, 32'd14, 32'd2, 1'b0);
        repeat (4) step();
        ctrl_div = 1'b1;
        op_a = 32'd1;
        op_b = 32'd1;
        step();
        ctrl_div = 1'b0;
        collect("ignore_restart", 33, 5, bc);
    endtask

    // Entered while the previous operation sits in DONE.
    task automatic test_back_to_back();
        int bc;
        start_op(32'd9, 32'd2, 32'd4, 32'd1, 1'b0);
        repeat (3) step();
        checks++;
        if (data_result !== 32'd14 || data_remainder !== 32'd2 || busy !== 1'b1) begin
            errors++;
            $display("FAIL b2b_hold_run: got %h/%h busy=%b, required 0000000e/00000002 busy=1",
                     data_result, data_remainder, busy);
        end
        collect("back_to_back", 33, 3, bc);
        step();
    endtask

    task automatic test_async_reset();
        int  bc;
        bit  seen;
        ctrl_div = 1'b1;
        op_a = 32'd100;
        op_b = 32'd7;
        step();
        ctrl_div = 1'b0;
        repeat (9) step();
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if ({data_result, data_remainder, data_exception, data_resultRDY, busy} !== '0) begin
            errors++;
            $display("FAIL async_reset_outputs: got res=%h rem=%h exc=%b rdy=%b busy=%b, required all 0",
                     data_result, data_remainder, data_exception, data_resultRDY, busy);
        end
        step();
        #3;
        reset_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (data_resultRDY || busy) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++;
            $display("FAIL async_reset_aborted: got rdy/busy activity after reset, required none");
        end
        start_op(32'd50, 32'd5, 32'd10, 32'd0, 1'b0);
        collect("after_reset_50_5", 33, 0, bc);
        step();
    endtask

    task automatic test_random();
        int bc;
        logic signed [W-1:0] da;
        logic signed [W-1:0] dv;
        logic signed [W-1:0] q;
        logic signed [W-1:0] r;
        for (int i = 0; i < 8; i++) begin
            da = $urandom;
            dv = (i % 2 == 0) ? $urandom : W'($urandom_range(1, 200));
            if (i % 4 == 1) dv = -dv;
            if (dv == 0) dv = 3;
            if (da == 32'sh8000_0000 && dv == -1) dv = 5;
            q = da / dv;
            r = da % dv;
            start_op(da, dv, q, r, 1'b0);
            collect("random", 33, 0, bc);
            step();
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_signed();
        test_div_zero();
        test_overflow();
        test_ignore_restart();
        test_back_to_back();
        test_async_reset();
        test_random();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, required 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/div_unit_seq.md
Name: div_unit_seq

Overview:
- Multicycle signed integer divider for the ALU/multdiv path. It is the inverse companion of the carry-lookahead adder tree.
- Uses restoring shift-subtract and produces one quotient bit per cycle.
- The trial subtraction is an internal WIDTH+1-bit subtract; it need not reuse the adder.
- Issue/complete handshake to the pipeline: ctrl_div pulse in, data_resultRDY pulse out.

Parameters:
- WIDTH, 32, operand/quotient/remainder width; must be >= 2.
- CNT_W, $clog2(WIDTH)+1, iteration counter width; derived, not overridden.

Ports:
- clock  input  1  rising-edge clock
- reset_n  input  1  asynchronous, active-low reset
- ctrl_div  input  1  start request, sampled on rising edge
- data_operandA  input  WIDTH  dividend, two's complement, sampled with ctrl_div
- data_operandB  input  WIDTH  divisor, two's complement, sampled with ctrl_div
- data_result  output  WIDTH  quotient, registered
- data_remainder  output  WIDTH  remainder, registered
- data_exception  output  1  divide-by-zero flag, registered
- data_resultRDY  output  1  one-cycle completion pulse
- busy  output  1  high while in RUN or FIX

Behaviour:
- Clock and reset: one clock. Reset is asynchronous and active-low.
- Reset (reset_n low, any state, including mid-operation):
  - state -> IDLE; counter, partial remainder and quotient shift registers -> 0.
  - data_result = 0, data_remainder = 0, data_exception = 0, data_resultRDY = 0, busy = 0.
  - The aborted operation never produces data_resultRDY.
- States: IDLE, RUN, FIX, DONE.
- Start acceptance:
  - ctrl_div is accepted only in IDLE or DONE. It is ignored in RUN and FIX: no restart, no effect on the operation in flight.
  - On acceptance, latch operands, signA = A[WIDTH-1], signB = B[WIDTH-1], magnitudes |A| and |B|.
  - |-2^(WIDTH-1)| = 2^(WIDTH-1), held unsigned.
- Divide-by-zero:
  - If B == 0 at acceptance, go to DONE next edge.
  - data_result = 0, data_remainder = 0, data_exception = 1.
  - data_resultRDY is high in the cycle after the accepting edge (latency 1).
- Otherwise go to RUN with counter = 0, remainder register R = 0, quotient shift register Q = |A|.
- RUN, each edge:
  - {R,Q} shifts left 1.
  - Trial T = R_shifted - |B| (WIDTH+1 bits).
  - If T >= 0, then R = T and Q[0] = 1; else R = R_shifted and Q[0] = 0.
  - counter++.
  - After the edge where counter reaches WIDTH, go to FIX.
  - Exactly WIDTH iterations.
- FIX, one edge:
  - data_result = (signA ^ signB) ? -Q : Q.
  - data_remainder = signA ? -R : R.
  - data_exception = 0.
  - Go to DONE.
- DONE:
  - data_resultRDY = 1 for exactly this one cycle.
  - Next edge: go to IDLE, or if ctrl_div is high, accept a new operation (back-to-back).
- Latency: ctrl_div accepted at edge k -> data_resultRDY high in the cycle after edge k+WIDTH+1. For WIDTH=32, RDY is visible after edge k+33.
- Output hold: data_result, data_remainder and data_exception change only on a FIX edge, on a divide-by-zero acceptance edge, or on reset. They hold their values through IDLE and through a later operation's RUN.
- Arithmetic rules:
  - Truncating division (round toward zero); the remainder takes the dividend's sign.
  - Overflow case -2^(WIDTH-1) / -1: quotient wraps to -2^(WIDTH-1), remainder 0, data_exception 0.
- busy = 1 in RUN and FIX only.
- Operand inputs need not be held stable after the accepting edge.

Test Plan:
- A=100, B=7, ctrl_div pulsed at edge k -> RDY exactly after edge k+33; result=14, remainder=2, exception=0; busy high for 33 cycles.
- A=-100 (0xFFFFFF9C), B=7 -> result=0xFFFFFFF2 (-14), remainder=0xFFFFFFFE (-2). Then A=100, B=-7 -> result=-14, remainder=2.
- A=5, B=0 -> RDY in the cycle after the accepting edge; exception=1, result=0, remainder=0. The next valid divide (A=9, B=3) clears exception and gives result=3, remainder=0.
- A=0x80000000, B=0xFFFFFFFF -> result=0x80000000, remainder=0, exception=0. A=0x80000000, B=1 -> result=0x80000000, remainder=0.
- ctrl_div re-pulsed at RUN cycle 5 with A=1, B=1 -> ignored; the original 100/7 completes at k+33 with 14/2. ctrl_div high during the DONE cycle with A=9, B=2 -> accepted; RDY 33 edges later with result=4, remainder=1.
- reset_n dropped asynchronously mid-clock at RUN cycle 10 -> all outputs 0 immediately; state IDLE; no RDY for the aborted op. Release, then A=50, B=5 -> result=10, remainder=0.
